// File: rtl/sm4_pkg.sv
// -----------------------------------------------------------------------------
// sm4_pkg
// Shared constants and types for the SM4 job arbiter slice.
//   SM4_BLOCK_W  : width of one SM4 block / key (bits)
//   SM4_CORE_LAT : nominal latency of the iterative round core (cycles)
//   sm4_state_e  : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package sm4_pkg;

    localparam int SM4_BLOCK_W  = 128;
    localparam int SM4_CORE_LAT = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } sm4_state_e;

endpackage : sm4_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Chooses the first asserted request
// at or after position ptr+1, wrapping modulo N_REQ. The pointer itself is
// owned and updated by the parent.
//   req       : request vector
//   ptr       : index of the most recently served requester
//   grant     : one-hot grant (all zero when no request is pending)
//   grant_idx : encoded index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    // One extra bit so ptr+1+k (at most 2*N_REQ-1) cannot overflow before the wrap.
    localparam int POS_W = IDX_W + 1;

    logic [POS_W-1:0] pos_s;
    logic             found_s;

    // Scan requesters in rotated order starting just after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        pos_s     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_s = {1'b0, ptr} + POS_W'(k + 1);
            if (pos_s >= POS_W'(N_REQ)) begin
                pos_s = pos_s - POS_W'(N_REQ);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s[IDX_W-1:0]]) begin
                found_s                   = 1'b1;
                grant[pos_s[IDX_W-1:0]]   = 1'b1;
                grant_idx                 = pos_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/sm4_job_arbiter.sv
// -----------------------------------------------------------------------------
// sm4_job_arbiter
// Shares one iterative SM4 round core between N_REQ requesters. One job is in
// flight at a time: the winning requester's text/key are captured, held on the
// core inputs with core_in_valid high for the whole job, and the core's
// one-cycle result pulse is returned to that requester over a valid/ready
// response channel. A watchdog aborts jobs the core never finishes, and a
// one-cycle idle gap guarantees the core sees a fresh in_valid rising edge.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   req_valid/ready : per-requester job handshake (ready is one-hot, IDLE only)
//   req_text/key    : packed per-requester plaintext / key, slice i = [128i+:128]
//   rsp_valid       : one-hot response pending for the job owner
//   rsp_ready       : per-requester response accept (only the owner's bit counts)
//   rsp_data/err    : result block; err=1 marks a watchdog abort with data 0
//   core_text/key   : held job inputs to the round core
//   core_in_valid   : high throughout a job
//   core_result     : core output block
//   core_out_valid  : core one-cycle completion pulse (ignored outside RUN)
// -----------------------------------------------------------------------------
module sm4_job_arbiter
    import sm4_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*SM4_BLOCK_W-1:0] req_text,
    input  logic [N_REQ*SM4_BLOCK_W-1:0] req_key,
    output logic [N_REQ-1:0]             rsp_valid,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic [SM4_BLOCK_W-1:0]       rsp_data,
    output logic                         rsp_err,
    output logic [SM4_BLOCK_W-1:0]       core_text,
    output logic [SM4_BLOCK_W-1:0]       core_key,
    output logic                         core_in_valid,
    input  logic [SM4_BLOCK_W-1:0]       core_result,
    input  logic                         core_out_valid
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    sm4_state_e             state_r;
    sm4_state_e             state_nxt_s;
    logic [IDX_W-1:0]       ptr_r;
    logic [SM4_BLOCK_W-1:0] job_text_r;
    logic [SM4_BLOCK_W-1:0] job_key_r;
    logic [SM4_BLOCK_W-1:0] rsp_data_r;
    logic                   rsp_err_r;
    logic [N_REQ-1:0]       rsp_valid_r;
    logic                   core_in_valid_r;
    logic [WD_W-1:0]        wd_r;

    logic [N_REQ-1:0]       grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [N_REQ-1:0]       req_ready_s;
    logic [N_REQ-1:0]       owner_onehot_s;
    logic                   accept_s;
    logic                   done_s;
    logic                   abort_s;
    logic                   rsp_hs_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // A job transfers on the single granted bit whenever IDLE sees any request.
    assign accept_s = (state_r == IDLE) && (|req_valid) && !reset;
    // Core completion only counts while a job is running; stray pulses are dropped.
    assign done_s   = (state_r == RUN) && core_out_valid;
    // Completion wins over a watchdog expiry landing in the same cycle.
    assign abort_s  = (state_r == RUN) && !core_out_valid && (wd_r == WD_W'(TIMEOUT - 1));
    // ptr_r still names the job owner while the response is pending.
    assign rsp_hs_s = (state_r == RESP) && rsp_ready[ptr_r];

    // Grant strobe back to the requesters; silent outside IDLE and during reset.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == IDLE) && !reset) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // One-hot decode of the current job owner for the response channel.
    always_comb begin
        owner_onehot_s        = '0;
        owner_onehot_s[ptr_r] = 1'b1;
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (done_s || abort_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            GAP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer and job capture; reset pointer makes requester 0 win first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r      <= IDX_W'(N_REQ - 1);
            job_text_r <= '0;
            job_key_r  <= '0;
        end else if (accept_s) begin
            ptr_r      <= grant_idx_s;
            job_text_r <= req_text[int'(grant_idx_s) * SM4_BLOCK_W +: SM4_BLOCK_W];
            job_key_r  <= req_key[int'(grant_idx_s) * SM4_BLOCK_W +: SM4_BLOCK_W];
        end
    end

    // Watchdog: cleared on accept, counts every RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_r <= '0;
        end else if (accept_s) begin
            wd_r <= '0;
        end else if (state_r == RUN) begin
            wd_r <= wd_r + WD_W'(1);
        end
    end

    // Core in_valid: high from the cycle after accept until the job leaves RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_in_valid_r <= 1'b0;
        end else if (accept_s) begin
            core_in_valid_r <= 1'b1;
        end else if (done_s || abort_s) begin
            core_in_valid_r <= 1'b0;
        end
    end

    // Result capture: core block on completion, forced zero with error on abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b0;
        end else if (done_s) begin
            rsp_data_r <= core_result;
            rsp_err_r  <= 1'b0;
        end else if (abort_s) begin
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b1;
        end
    end

    // Response valid to the job owner, held until that owner accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= '0;
        end else if (done_s || abort_s) begin
            rsp_valid_r <= owner_onehot_s;
        end else if (rsp_hs_s) begin
            rsp_valid_r <= '0;
        end
    end

    assign req_ready     = req_ready_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;
    assign core_text     = job_text_r;
    assign core_key      = job_key_r;
    assign core_in_valid = core_in_valid_r;

endmodule : sm4_job_arbiter

// File: tb/tb_sm4_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sm4_job_arbiter
// Scoreboard bench: stimulus pushes expected grants/responses into queues, an
// independent negedge monitor pops and compares on every grant and response
// handshake. A small behavioural core model answers jobs 33 cycles after
// in_valid rises (known-answer vector for the reference block, text^key else).
// -----------------------------------------------------------------------------
module tb_sm4_job_arbiter;

    localparam int N       = 4;
    localparam int TO      = 40;
    localparam int CORE_LT = 33;

    localparam logic [127:0] KAT_T = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_C = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] KEY_F = {32{4'hF}};

    typedef struct packed {
        logic [1:0]   idx;
        logic [127:0] data;
        logic         err;
    } rsp_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*128-1:0] req_text;
    logic [N*128-1:0] req_key;
    logic [N-1:0] rsp_valid;
    logic [N-1:0] rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic [127:0] core_text;
    logic [127:0] core_key;
    logic         core_in_valid;
    logic [127:0] core_result;
    logic         core_out_valid;

    logic         mute;
    logic         cov_model;
    logic         cov_stray;
    logic [127:0] res_model;
    logic [127:0] lat_text;
    logic [127:0] lat_key;
    int           core_cnt;

    rsp_t exp_rsp_q[$];
    int   exp_gnt_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_gnt = 0;
    int   n_rsp = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   last_lat = 0;
    int   civ_bad = 0;
    int   stable_bad = 0;
    logic in_job = 1'b0;
    logic gap_due = 1'b0;

    // Hand-computed per-requester texts and text^KEY_F results.
    logic [127:0] txt [4];
    logic [127:0] xr  [4];

    sm4_job_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_text       (req_text),
        .req_key        (req_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .core_text      (core_text),
        .core_key       (core_key),
        .core_in_valid  (core_in_valid),
        .core_result    (core_result),
        .core_out_valid (core_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign core_out_valid = cov_model | cov_stray;
    assign core_result    = cov_stray ? {8{16'hA5C3}} : res_model;

    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == KAT_T && k == KAT_T) return KAT_C;
        return t ^ k;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [127:0] t, input logic [127:0] k);
        req_text[128*i +: 128] = t;
        req_key[128*i +: 128]  = k;
    endtask

    task automatic wait_gnt(input int target);
        int b = 0;
        while (n_gnt < target && b < 300) begin
            tick();
            b++;
        end
        if (n_gnt < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", n_gnt, target);
        end
    endtask

    task automatic wait_rsp(input int target);
        int b = 0;
        while (n_rsp < target && b < 300) begin
            tick();
            b++;
        end
        if (n_rsp < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL response_timeout: got %0d responses expected %0d", n_rsp, target);
        end
    endtask

    task automatic push_rsp(input logic [1:0] i, input logic [127:0] d, input logic e);
        rsp_t r;
        r.idx  = i;
        r.data = d;
        r.err  = e;
        exp_rsp_q.push_back(r);
    endtask

    // Core model: answers CORE_LT cycles after in_valid rises unless muted.
    initial begin
        cov_model = 1'b0;
        res_model = '0;
        lat_text  = '0;
        lat_key   = '0;
        core_cnt  = 0;
        forever begin
            @(negedge clk);
            cov_model = 1'b0;
            if (reset || !core_in_valid) begin
                core_cnt = 0;
            end else begin
                if (core_cnt == 0) begin
                    lat_text = core_text;
                    lat_key  = core_key;
                end else if (core_text !== lat_text || core_key !== lat_key) begin
                    stable_bad++;
                end
                core_cnt++;
                if (core_cnt == CORE_LT && !mute) begin
                    cov_model = 1'b1;
                    res_model = core_fn(core_text, core_key);
                end
            end
        end
    end

    // Monitor: checks grants and response handshakes against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_job  = 1'b0;
                gap_due = 1'b0;
            end else begin
                if (gap_due) begin
                    chk("gap_civ_low", core_in_valid, 0);
                    chk("gap_no_ready", req_ready, 0);
                    gap_due = 1'b0;
                end
                if (in_job && rsp_valid == '0 && !core_in_valid) civ_bad++;
                if (in_job && rsp_valid != '0) begin
                    in_job   = 1'b0;
                    last_lat = cyc - gnt_cyc;
                end
                if ((req_valid & req_ready) != '0) begin
                    int gi;
                    gi = 0;
                    for (int b = 0; b < N; b++) if (req_ready[b]) gi = b;
                    chk("ready_onehot", $onehot(req_ready), 1);
                    chk("ready_subset", req_ready & ~req_valid, 0);
                    if (exp_gnt_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_grant: got requester %0d expected none", gi);
                    end else begin
                        chk("grant_order", gi, exp_gnt_q.pop_front());
                    end
                    n_gnt++;
                    in_job  = 1'b1;
                    gnt_cyc = cyc;
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    int ri;
                    rsp_t e;
                    ri = 0;
                    for (int b = 0; b < N; b++) if (rsp_valid[b]) ri = b;
                    chk("rsp_onehot", $onehot(rsp_valid), 1);
                    if (exp_rsp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_response: got requester %0d expected none", ri);
                    end else begin
                        e = exp_rsp_q.pop_front();
                        chk("rsp_owner", ri, e.idx);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    n_rsp++;
                    gap_due = 1'b1;
                end
            end
            cyc++;
        end
    end

    // Directed stimulus.
    initial begin
        int g;
        int r;
        int b;
        txt[0] = {32{4'h1}}; txt[1] = {32{4'h2}}; txt[2] = {32{4'h3}}; txt[3] = {32{4'h4}};
        xr[0]  = {32{4'hE}}; xr[1]  = {32{4'hD}}; xr[2]  = {32{4'hC}}; xr[3]  = {32{4'hB}};
        reset = 1'b1; req_valid = '0; rsp_ready = '0; req_text = '0; req_key = '0;
        mute = 1'b0; cov_stray = 1'b0;
        repeat (3) tick();

        // Reset state, including a grant attempt while reset is held.
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_core_text", core_text, 0);
        chk("rst_core_key", core_key, 0);
        req_valid = '0;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Stray core pulse in IDLE must be ignored.
        cov_stray = 1'b1;
        tick();
        cov_stray = 1'b0;
        repeat (3) begin
            tick();
            chk("stray_no_rsp", rsp_valid, 0);
            chk("stray_civ_low", core_in_valid, 0);
            chk("stray_data", rsp_data, 0);
        end

        // Single known-answer job on requester 0.
        rsp_ready = 4'hF;
        set_req(0, KAT_T, KAT_T);
        exp_gnt_q.push_back(0);
        push_rsp(2'd0, KAT_C, 1'b0);
        req_valid = 4'b0001;
        wait_gnt(n_gnt + 1);
        req_valid = '0;
        wait_rsp(n_rsp + 1);
        chk("kat_latency", last_lat, 34);

        // Contention from reset: all four held valid, expect 0,1,2,3,0.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, txt[i], KEY_F);
        for (int j = 0; j < 5; j++) begin
            exp_gnt_q.push_back(j % N);
            push_rsp(2'(j % N), xr[j % N], 1'b0);
        end
        g = n_gnt; r = n_rsp;
        req_valid = 4'hF;
        wait_gnt(g + 5);
        req_valid = '0;
        wait_rsp(r + 5);

        // Response backpressure on requester 1 with requester 2 waiting.
        g = n_gnt; r = n_rsp;
        rsp_ready = 4'b1101;
        exp_gnt_q.push_back(1); push_rsp(2'd1, xr[1], 1'b0);
        exp_gnt_q.push_back(2); push_rsp(2'd2, xr[2], 1'b0);
        req_valid = 4'b0110;
        wait_gnt(g + 1);
        req_valid[1] = 1'b0;
        b = 0;
        while (!rsp_valid[1] && b < 300) begin tick(); b++; end
        chk("bp_rsp_arrived", rsp_valid, 4'b0010);
        repeat (20) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, 4'b0010);
            chk("bp_rsp_data", rsp_data, xr[1]);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_no_core_start", core_in_valid, 0);
        end
        rsp_ready[1] = 1'b1;
        wait_gnt(g + 2);
        req_valid[2] = 1'b0;
        wait_rsp(r + 2);

        // Watchdog abort, then a normal job.
        mute = 1'b1;
        g = n_gnt; r = n_rsp;
        exp_gnt_q.push_back(3); push_rsp(2'd3, 128'h0, 1'b1);
        req_valid = 4'b1000;
        wait_gnt(g + 1);
        req_valid = '0;
        wait_rsp(r + 1);
        chk("wd_latency", last_lat, TO + 1);
        mute = 1'b0;
        exp_gnt_q.push_back(1); push_rsp(2'd1, xr[1], 1'b0);
        req_valid = 4'b0010;
        wait_gnt(g + 2);
        req_valid = '0;
        wait_rsp(r + 2);

        // Reset ten cycles into a job on requester 0.
        g = n_gnt; r = n_rsp;
        exp_gnt_q.push_back(0);
        req_valid = 4'b0001;
        wait_gnt(g + 1);
        req_valid = '0;
        repeat (10) tick();
        chk("mid_civ_high", core_in_valid, 1);
        req_valid = 4'b0101;
        reset = 1'b1;
        #1;
        chk("mid_rst_civ", core_in_valid, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_text", core_text, 0);
        chk("mid_rst_key", core_key, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_err", rsp_err, 0);
        tick();
        reset = 1'b0;
        exp_gnt_q.push_back(0); push_rsp(2'd0, xr[0], 1'b0);
        exp_gnt_q.push_back(2); push_rsp(2'd2, xr[2], 1'b0);
        wait_gnt(g + 2);
        req_valid[0] = 1'b0;
        wait_gnt(g + 3);
        req_valid[2] = 1'b0;
        wait_rsp(r + 2);
        repeat (3) tick();

        chk("civ_continuous", civ_bad, 0);
        chk("core_input_stable", stable_bad, 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);
        chk("gnt_queue_drained", exp_gnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sm4_job_arbiter

// File: doc/sm4_job_arbiter.md
# sm4_job_arbiter

Round-robin controller that shares one iterative SM4 round core (32-round, single-block, key expansion on the fly) between `N_REQ` independent requesters. It accepts one block job at a time, holds the core's plaintext, key and `in_valid` stable for the whole job, and captures the core's one-cycle result pulse. It returns the result to the originating requester through a valid/ready response channel and enforces the idle gap the core needs between jobs. It sits between the system-side encrypt clients and the core.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 40: cycles in RUN before the watchdog aborts a job; must exceed core latency (34).
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: per-requester job request.
- `req_ready` out N_REQ: one-hot accept; a job transfers on `req_valid[i] & req_ready[i]`.
- `req_text` in N_REQ*128: plaintext, slice i = bits [128*i+127 : 128*i].
- `req_key` in N_REQ*128: user key, same slicing.
- `rsp_valid` out N_REQ: one-hot; response pending for requester i.
- `rsp_ready` in N_REQ: per-requester response accept.
- `rsp_data` out 128: result, word order as delivered by the core.
- `rsp_err` out 1: qualifies `rsp_data`; 1 = watchdog abort, data forced to 0.
- `core_text` out 128: to core plaintext input.
- `core_key` out 128: to core key input.
- `core_in_valid` out 1: to core in_valid.
- `core_result` in 128: from core.
- `core_out_valid` in 1: from core, one-cycle pulse.

## Operation
- FSM states: IDLE, RUN, RESP, GAP.
- IDLE: if any `req_valid`, the arbiter grants requester g and drives `req_ready[g]=1` combinationally in that cycle.
  - g is chosen round-robin: the first set bit at or after `ptr+1`, wrapping modulo N_REQ.
  - On the clock edge the block latches `req_text[g]`/`req_key[g]` into job registers, sets `ptr<=g`, clears the watchdog and moves to RUN.
- RUN: `core_in_valid=1`. `core_text`/`core_key` come from the job registers and are stable for the whole state.
  - The watchdog increments every cycle.
  - On `core_out_valid`, the block latches `core_result` into `rsp_data`, clears `rsp_err` and moves to RESP.
  - If the watchdog reaches TIMEOUT-1 without `core_out_valid`, the block sets `rsp_data=0`, `rsp_err=1` and moves to RESP.
- RESP: `rsp_valid[g]=1`; `rsp_data` and `rsp_err` are held. When `rsp_ready[g]=1`, the block moves to GAP. `rsp_ready` of other requesters is ignored.
- GAP: exactly one cycle with `core_in_valid=0`, so the core sees a fresh rising edge for the next job. Then the block returns to IDLE.
- `req_ready` is all-zero outside IDLE. New requests wait and are not dropped.
- `core_out_valid` outside RUN is ignored and does not change state or data.
- Reset values:
  - state = IDLE, `ptr = N_REQ-1` (requester 0 wins first).
  - `req_ready`, `rsp_valid`, `core_in_valid`, `rsp_err` = 0.
  - `rsp_data`, `core_text`, `core_key`, job registers = 0.
- Reset mid-job (any state): immediate return to reset values. The in-flight job is lost with no response. Dropping `core_in_valid` also resets the core's round counter.

## Timing
- Accept edge (cycle A, IDLE): `core_in_valid` rises at A+1.
- Core result arrives about 33 cycles after its in_valid rising edge. `rsp_valid` rises the cycle after `core_out_valid`.
- Response handshake in cycle R: GAP at R+1, IDLE at R+2. The earliest next accept is in cycle R+2.
- Minimum job-to-job spacing is core latency + 3 cycles when `rsp_ready` is held high.
- Simultaneous requests: exactly one grant per IDLE cycle, strictly round-robin. No requester waits more than N_REQ-1 jobs.
- `req_valid` may drop before being granted; there is no penalty and no state change.

## Structure
- Package `sm4_pkg`: `SM4_BLOCK_W=128`, `SM4_CORE_LAT=34`, state typedef {IDLE, RUN, RESP, GAP}.
- One sub-module, `rr_arbiter`: inputs are the request vector and `ptr`; output is the one-hot grant plus the encoded index. It is purely combinational; the pointer update stays in the top.
- Top: FSM, job/result registers, watchdog counter of width clog2(TIMEOUT).

## Test plan
- Single job:
  - Stimulus: requester 0, key = text = 0123456789abcdeffedcba9876543210.
  - Required: `rsp_valid[0]` with `rsp_data`=681edf34d206965e86b3e94f536e4246, `rsp_err`=0. `core_in_valid` stays high continuously from A+1 until the result.
- Contention:
  - Stimulus: all 4 requesters held valid from reset, `rsp_ready` held high.
  - Required: grant order 0,1,2,3,0. Each response goes only to its owner. A 1-cycle `core_in_valid` low appears between every pair of jobs.
- Response backpressure:
  - Stimulus: `rsp_ready[1]` held low for 20 cycles.
  - Required: `rsp_valid[1]`/`rsp_data` stay stable, `req_ready`=0 throughout, and no core start occurs.
- Watchdog:
  - Stimulus: core model never pulses `core_out_valid`.
  - Required: after 40 RUN cycles, `rsp_err`=1 and `rsp_data`=0. The next job then proceeds normally.
- Reset mid-RUN:
  - Stimulus: assert `reset` 10 cycles into a job.
  - Required: all outputs 0 in the same cycle and no response is issued. After release, requester 0 has priority again.
- Stray pulse:
  - Stimulus: `core_out_valid` pulsed in IDLE.
  - Required: no `rsp_valid` and no state change.
